axi_lite_target_mem: RTL

- AXI4-Lite responder: a small word-addressed memory that is the slave end for the block's M00_AXI master.
- Lets the M00_AXI write/read/compare sequence (INIT_AXI_TXN -> TXN_DONE/ERROR) run against real RTL instead of a BFM slave.
- Accepts AW/W/AR independently, issues B and R responses.
- Flags accesses outside its window with SLVERR.

---
 rtl/axi_lite_target_mem.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_target_mem.sv
// axi_lite_target_mem: AXI4-Lite slave backed by a small word-addressed memory.
// Write (AW/W -> B) and read (AR -> R) channels run as two independent FSMs.
// Accesses outside [C_BASE_ADDR, C_BASE_ADDR + 4*C_NUM_WORDS) get SLVERR.
// Optional build macro RESP_DELAY_EN: when defined, BVALID/RVALID are held back
// by C_RESP_DELAY cycles using a per-channel down-counter.
module axi_lite_target_mem #(
    parameter int                          C_ADDR_WIDTH = 32,
    parameter int                          C_DATA_WIDTH = 32,
    parameter int                          C_NUM_WORDS  = 16,
    parameter logic [C_ADDR_WIDTH-1:0]     C_BASE_ADDR  = 32'h4000_0000,
    parameter int                          C_RESP_DELAY = 3
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]              S_AXI_AWPROT,
    input  logic                    S_AXI_AWVALID,
    output logic                    S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [3:0]              S_AXI_WSTRB,
    input  logic                    S_AXI_WVALID,
    output logic                    S_AXI_WREADY,
    output logic [1:0]              S_AXI_BRESP,
    output logic                    S_AXI_BVALID,
    input  logic                    S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]              S_AXI_ARPROT,
    input  logic                    S_AXI_ARVALID,
    output logic                    S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]              S_AXI_RRESP,
    output logic                    S_AXI_RVALID,
    input  logic                    S_AXI_RREADY
);

    localparam int IDX_W = $clog2(C_NUM_WORDS);
    localparam logic [C_ADDR_WIDTH-1:0] WINDOW_BYTES = C_ADDR_WIDTH'(C_NUM_WORDS * 4);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic W_ACCEPT = 1'b0;
    localparam logic W_RESP   = 1'b1;
    localparam logic R_ACCEPT = 1'b0;
    localparam logic R_RESP   = 1'b1;

    logic [C_DATA_WIDTH-1:0] mem [C_NUM_WORDS];

    // Write channel state
    logic                    w_state;
    logic                    awready_q;
    logic                    wready_q;
    logic                    aw_held;
    logic                    w_held;
    logic [C_ADDR_WIDTH-1:0] aw_addr_q;
    logic [C_DATA_WIDTH-1:0] w_data_q;
    logic [3:0]              w_strb_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;

    // Read channel state
    logic                    r_state;
    logic                    arready_q;
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic [C_DATA_WIDTH-1:0] rdata_q;

`ifdef RESP_DELAY_EN
    logic [3:0]              b_cnt_q;
    logic [3:0]              r_cnt_q;
`endif

    // Handshakes and the effective write address/data for this edge
    logic                    aw_hs;
    logic                    w_hs;
    logic                    ar_hs;
    logic                    wr_commit;
    logic [C_ADDR_WIDTH-1:0] wr_addr;
    logic [C_DATA_WIDTH-1:0] wr_data;
    logic [3:0]              wr_strb;
    logic [C_ADDR_WIDTH-1:0] wr_off;
    logic                    wr_hit;
    logic [IDX_W-1:0]        wr_idx;
    logic [C_ADDR_WIDTH-1:0] rd_off;
    logic                    rd_hit;
    logic [IDX_W-1:0]        rd_idx;
    logic                    unused_inputs;

    assign aw_hs = S_AXI_AWVALID & awready_q;
    assign w_hs  = S_AXI_WVALID & wready_q;
    assign ar_hs = S_AXI_ARVALID & arready_q;

    // The half that arrives on this edge is taken from the bus, the other from its holding register
    assign wr_addr = aw_hs ? S_AXI_AWADDR : aw_addr_q;
    assign wr_data = w_hs ? S_AXI_WDATA : w_data_q;
    assign wr_strb = w_hs ? S_AXI_WSTRB : w_strb_q;

    assign wr_commit = (w_state == W_ACCEPT) && (aw_hs || aw_held) && (w_hs || w_held);

    // The >= test rejects addresses below the base whose subtraction would wrap
    assign wr_off = wr_addr - C_BASE_ADDR;
    assign wr_hit = (wr_addr >= C_BASE_ADDR) && (wr_off < WINDOW_BYTES);
    assign wr_idx = wr_off[IDX_W+1:2];

    assign rd_off = S_AXI_ARADDR - C_BASE_ADDR;
    assign rd_hit = (S_AXI_ARADDR >= C_BASE_ADDR) && (rd_off < WINDOW_BYTES);
    assign rd_idx = rd_off[IDX_W+1:2];

`ifdef RESP_DELAY_EN
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT};
`else
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, 4'(C_RESP_DELAY)};
`endif

    // Write FSM: collect AW and W in either order, commit, then hold B until accepted
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state   <= W_ACCEPT;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
`ifdef RESP_DELAY_EN
            b_cnt_q   <= '0;
`endif
        end else begin
            case (w_state)
                W_ACCEPT: begin
                    if (wr_commit) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        bresp_q   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
`ifdef RESP_DELAY_EN
                        b_cnt_q   <= 4'(C_RESP_DELAY);
`else
                        bvalid_q  <= 1'b1;
`endif
                        w_state   <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_addr_q <= S_AXI_AWADDR;
                            aw_held   <= 1'b1;
                            awready_q <= 1'b0;
                        end else if (!aw_held) begin
                            awready_q <= 1'b1;
                        end
                        if (w_hs) begin
                            w_data_q <= S_AXI_WDATA;
                            w_strb_q <= S_AXI_WSTRB;
                            w_held   <= 1'b1;
                            wready_q <= 1'b0;
                        end else if (!w_held) begin
                            wready_q <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
`ifdef RESP_DELAY_EN
                    if (!bvalid_q) begin
                        if (b_cnt_q <= 4'd1) begin
                            b_cnt_q  <= '0;
                            bvalid_q <= 1'b1;
                        end else begin
                            b_cnt_q <= b_cnt_q - 4'd1;
                        end
                    end else if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_ACCEPT;
                    end
`else
                    if (bvalid_q && S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state   <= W_ACCEPT;
                    end
`endif
                end
                default: w_state <= W_ACCEPT;
            endcase
        end
    end

    // Memory array: cleared by reset, byte-masked update on an in-window commit
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < C_NUM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_commit && wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read FSM: capture data at the AR handshake (pre-write value on a same-edge collision), hold R until accepted
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= R_ACCEPT;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
`ifdef RESP_DELAY_EN
            r_cnt_q   <= '0;
`endif
        end else begin
            case (r_state)
                R_ACCEPT: begin
                    if (ar_hs) begin
                        rdata_q   <= rd_hit ? mem[rd_idx] : '0;
                        rresp_q   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                        arready_q <= 1'b0;
`ifdef RESP_DELAY_EN
                        r_cnt_q   <= 4'(C_RESP_DELAY);
`else
                        rvalid_q  <= 1'b1;
`endif
                        r_state   <= R_RESP;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_RESP: begin
`ifdef RESP_DELAY_EN
                    if (!rvalid_q) begin
                        if (r_cnt_q <= 4'd1) begin
                            r_cnt_q  <= '0;
                            rvalid_q <= 1'b1;
                        end else begin
                            r_cnt_q <= r_cnt_q - 4'd1;
                        end
                    end else if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_ACCEPT;
                    end
`else
                    if (rvalid_q && S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_ACCEPT;
                    end
`endif
                end
                default: r_state <= R_ACCEPT;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

endmodule
